serial_packet_demux: RTL
========================

Name: serial_packet_demux

Overview:
- Parametrised serial-frame receiver and router: deserialises a header (destination address + payload length) from a single serial line, then steers each payload bit to one of 2**ADDR_W outputs with a one-hot valid strobe.
- Integrates its own controller FSM, so no external shift-register enables are needed.
- Sits between the serial input pin and the per-port consumers.

Parameters:
- ADDR_W, 4, destination address width; output count NUM_OUT = 2**ADDR_W (16).
- LEN_W, 6, payload length field width; maximum payload is 2**LEN_W-1 bits (63).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- serIn  input  1  serial data; idle level 1.
- dout  output  NUM_OUT  routed payload bit; only the addressed bit is meaningful, all others 0.
- dout_valid  output  NUM_OUT  one-hot strobe; bit addr_q high for the cycle dout[addr_q] carries a payload bit.
- addr_q  output  ADDR_W  latched destination address of the current/last frame.
- len_q  output  LEN_W  latched payload length of the current/last frame.
- busy  output  1  high from the start bit until the frame ends.
- done  output  1  one-cycle pulse at end of frame.
- err  output  1  parity error flag, valid with done (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: FSM=IDLE; dout, dout_valid, addr_q, len_q, busy, done, err and bit counter all 0.
- FSM states: IDLE, ADDR, LEN, PAYLOAD, PARITY (only with the macro), DONE.
- IDLE: serIn==0 sampled on a clock edge is the start bit -> ADDR, busy=1, counter=0. serIn==1 stays in IDLE.
- ADDR: shifts serIn into addr_q MSB first, ADDR_W cycles, then -> LEN with counter cleared.
- LEN: shifts serIn into len_q MSB first, LEN_W cycles.
  - On the last bit, if the assembled length is 0 -> DONE (or PARITY if enabled); else -> PAYLOAD.
- PAYLOAD: lasts exactly len_q cycles.
  - Each edge registers dout[addr_q]<=serIn and dout_valid<=one-hot(addr_q); all other bits are 0.
  - Latency: serIn bit sampled at edge k appears on dout/dout_valid after edge k (one register stage).
  - Counter counts payload bits; at count len_q-1 -> DONE (or PARITY).
- dout_valid and dout return to 0 on the edge after the last payload bit.
- DONE: done=1 for exactly one cycle, busy=0 in this cycle, -> IDLE.
  - serIn in the DONE cycle is ignored; a new start bit is accepted from the following cycle.
- addr_q and len_q hold their values after DONE until the next frame's ADDR/LEN shifting overwrites them.
- Counter width is max(ADDR_W, LEN_W); no wrap can occur because each state's terminal count is at most 2**LEN_W-1.
- rst mid-frame: abort immediately to IDLE with reset values; no done pulse for the aborted frame.
- Header bits equal to 0 are not mistaken for start bits; the start bit is only recognised in IDLE.

Optional Feature:
- Macro: SERIAL_DEMUX_PARITY_EN.
- Defined:
  - After the payload (or after LEN when len is 0) the FSM enters PARITY for one cycle and samples serIn as an even-parity bit over the payload bits.
  - In DONE, err=1 if XOR(payload bits, parity bit) != 0, else err=0.
  - err holds until the next start bit is accepted, where it is cleared.
  - Frame length grows by 1 bit.
- Not defined: no PARITY state, err tied to 0, frame format without a parity bit.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then serIn=1 for 20 cycles -> all outputs 0, busy=0, no done.
- Basic frame (defaults):
  - Stimulus: start 0, addr 1010, len 000011, payload 1,0,1.
  - Response: addr_q=10, len_q=3; dout_valid=16'h0400 for 3 consecutive cycles; dout[10] follows 1,0,1 one cycle after sampling; done pulse one cycle after the last valid; busy high for 1+4+6+3 cycles.
- Zero length: addr 0011, len 000000 -> no dout_valid activity, done pulses right after the LEN phase, addr_q=3.
- Back-to-back and maximum length:
  - Stimulus: frame to addr 15 with len 63 (alternating payload), then a start bit in the cycle after DONE.
  - Response: 63 valid cycles on bit 15; the second frame is accepted with no lost bit.
- Reset mid-payload: assert rst during payload bit 2 of a len=5 frame -> next cycle all outputs 0, no done; a following clean frame is received correctly.
- Parity (macro defined): payload 1,1,0 with parity bit 0 -> err=0 at done; same payload with parity bit 1 -> err=1 at done, cleared at the next start bit.

Source files
------------

// File: rtl/serial_packet_demux.sv
// serial_packet_demux
// Serial-frame receiver and router. A frame is a start bit (0), an ADDR_W-bit
// destination address (MSB first), a LEN_W-bit payload length (MSB first) and
// then len payload bits. Every payload bit is registered onto dout[addr_q]
// with a one-hot strobe on dout_valid.
// Optional feature macro: SERIAL_DEMUX_PARITY_EN adds a trailing even-parity
// bit after the payload and reports a mismatch on err together with done.
module serial_packet_demux #(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   serIn,
  output logic [(2**ADDR_W)-1:0] dout,
  output logic [(2**ADDR_W)-1:0] dout_valid,
  output logic [ADDR_W-1:0]      addr_q,
  output logic [LEN_W-1:0]       len_q,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int NUM_OUT = 2**ADDR_W;
  localparam int CNT_W   = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_W - 1);

`ifdef SERIAL_DEMUX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PARITY  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;
  // The frame tail goes through the parity slot before completing.
  localparam state_t ST_TAIL = ST_PARITY;
  localparam logic   PAR_EN  = 1'b1;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DONE    = 3'd5
  } state_t;
  localparam state_t ST_TAIL = ST_DONE;
  localparam logic   PAR_EN  = 1'b0;
`endif

  state_t               state_r;
  state_t               state_next_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [ADDR_W-1:0]    addr_r;
  logic [LEN_W-1:0]     len_r;
  logic [NUM_OUT-1:0]   dout_r;
  logic [NUM_OUT-1:0]   valid_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 err_r;
  logic                 par_r;

  logic [LEN_W-1:0]     len_full_s;
  logic [CNT_W-1:0]     pay_last_s;
  logic [NUM_OUT-1:0]   onehot_s;

  // Length as it will look once the bit currently on serIn is shifted in.
  assign len_full_s = {len_r[LEN_W-2:0], serIn};
  // Terminal payload count; only used while len_r is non-zero.
  assign pay_last_s = CNT_W'(len_r) - CNT_W'(1'b1);
  assign onehot_s   = {{(NUM_OUT-1){1'b0}}, 1'b1} << addr_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic for the frame controller.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (serIn == 1'b0) begin
          state_next_s = ST_ADDR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (cnt_r == ADDR_LAST) begin
          state_next_s = ST_LEN;
        end else begin
          state_next_s = ST_ADDR;
        end
      end
      ST_LEN: begin
        if (cnt_r == LEN_LAST) begin
          if (len_full_s == {LEN_W{1'b0}}) begin
            state_next_s = ST_TAIL;
          end else begin
            state_next_s = ST_PAYLOAD;
          end
        end else begin
          state_next_s = ST_LEN;
        end
      end
      ST_PAYLOAD: begin
        if (cnt_r == pay_last_s) begin
          state_next_s = ST_TAIL;
        end else begin
          state_next_s = ST_PAYLOAD;
        end
      end
`ifdef SERIAL_DEMUX_PARITY_EN
      ST_PARITY: begin
        state_next_s = ST_DONE;
      end
`endif
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Bit counter: restarts on every state change, counts within a field.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r != state_next_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_ADDR) || (state_r == ST_LEN) || (state_r == ST_PAYLOAD)) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Header capture, payload routing, parity accumulation and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= {ADDR_W{1'b0}};
      len_r   <= {LEN_W{1'b0}};
      dout_r  <= {NUM_OUT{1'b0}};
      valid_r <= {NUM_OUT{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      par_r   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      dout_r  <= {NUM_OUT{1'b0}};
      valid_r <= {NUM_OUT{1'b0}};
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (serIn == 1'b0) begin
            busy_r <= 1'b1;
            err_r  <= 1'b0;
            par_r  <= 1'b0;
          end
        end
        ST_ADDR: begin
          addr_r <= {addr_r[ADDR_W-2:0], serIn};
        end
        ST_LEN: begin
          len_r <= len_full_s;
        end
        ST_PAYLOAD: begin
          dout_r  <= serIn ? onehot_s : {NUM_OUT{1'b0}};
          valid_r <= onehot_s;
          par_r   <= par_r ^ serIn;
        end
`ifdef SERIAL_DEMUX_PARITY_EN
        ST_PARITY: begin
          par_r <= par_r ^ serIn;
        end
`endif
        ST_DONE: begin
          // serIn is deliberately not looked at here.
          busy_r <= 1'b0;
          done_r <= 1'b1;
          err_r  <= PAR_EN & par_r;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = dout_r;
  assign dout_valid = valid_r;
  assign addr_q     = addr_r;
  assign len_q      = len_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule
